// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered-output ALU between two requesters.
// One operation is in flight at a time. The accepted operands are held in
// registers, presented to the ALU for two cycles, and the result is returned
// as a tagged response that stays put until the consumer takes it.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int FAIR  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  state_t           state;
  state_t           next_state;
  logic             last_grant;
  logic             grant;
  logic             any_valid;
  logic             accept;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_legal;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             err_q;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: is_legal = 1'b1;
      default:                               is_legal = 1'b0;
    endcase
  endfunction

  // Pick a requester from the valids: a lone valid wins, a tie goes to the
  // one not served last (round-robin) or to requester 0 (fixed priority).
  always_comb begin
    grant     = 1'b0;
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = (FAIR != 0) ? ~last_grant : 1'b0;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    sel_op    = grant ? req1_op : req0_op;
    sel_a     = grant ? req1_a  : req0_a;
    sel_b     = grant ? req1_b  : req0_b;
    sel_legal = is_legal(sel_op);
  end

  // Next-state and per-state outputs; the ALU only sees real operands in
  // EXEC and CAPT, otherwise an AND of zeros that cannot disturb alu_zero.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = OP_AND;
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          next_state = sel_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        alu_a      = a_q;
        alu_b      = b_q;
        alu_ctrl   = op_q;
        next_state = CAPT;
      end
      CAPT: begin
        alu_a      = a_q;
        alu_b      = b_q;
        alu_ctrl   = op_q;
        next_state = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus the operand, response and fairness registers; a reset
  // anywhere drops the in-flight operation without producing a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      data_q     <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_q       <= sel_op;
        a_q        <= sel_a;
        b_q        <= sel_b;
        id_q       <= grant;
        last_grant <= grant;
        data_q     <= '0;
        zero_q     <= 1'b0;
        err_q      <= ~sel_legal;
      end
      if (state == CAPT) begin
        data_q <= alu_result;
        zero_q <= (op_q == OP_SUB) ? alu_zero : 1'b0;
      end
      if (state == RESP && resp_ready) begin
        data_q <= '0;
        zero_q <= 1'b0;
        err_q  <= 1'b0;
        id_q   <= 1'b0;
      end
    end
  end

  // Response port is a straight view of the held response registers.
  always_comb begin
    resp_valid = (state == RESP);
    resp_id    = id_q;
    resp_data  = data_q;
    resp_zero  = zero_q;
    resp_err   = err_q;
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter. Two instances share the
// request inputs: rr uses round-robin, fp uses fixed priority. Each drives
// its own model of the registered ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [3:0]  req0_op = '0;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic        req1_valid = 1'b0;
  logic [3:0]  req1_op = '0;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic        resp_ready = 1'b0;

  logic        rr_req0_ready, rr_req1_ready, rr_resp_valid, rr_resp_id;
  logic        rr_resp_zero, rr_resp_err, rr_busy;
  logic [31:0] rr_resp_data, rr_alu_a, rr_alu_b;
  logic [3:0]  rr_alu_ctrl;
  logic [31:0] rr_alu_result = '0;
  logic        rr_alu_zero = 1'b0;

  logic        fp_req0_ready, fp_req1_ready, fp_resp_valid, fp_resp_id;
  logic        fp_resp_zero, fp_resp_err, fp_busy;
  logic [31:0] fp_resp_data, fp_alu_a, fp_alu_b;
  logic [3:0]  fp_alu_ctrl;
  logic [31:0] fp_alu_result = '0;
  logic        fp_alu_zero = 1'b0;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(32), .FAIR(1)) rr_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(rr_resp_valid), .resp_ready(resp_ready), .resp_id(rr_resp_id),
    .resp_data(rr_resp_data), .resp_zero(rr_resp_zero), .resp_err(rr_resp_err),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_ctrl(rr_alu_ctrl),
    .alu_result(rr_alu_result), .alu_zero(rr_alu_zero), .busy(rr_busy)
  );

  alu_arbiter #(.WIDTH(32), .FAIR(0)) fp_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_id(fp_resp_id),
    .resp_data(fp_resp_data), .resp_zero(fp_resp_zero), .resp_err(fp_resp_err),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_ctrl(fp_alu_ctrl),
    .alu_result(fp_alu_result), .alu_zero(fp_alu_zero), .busy(fp_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_calc(input logic [3:0] ctrl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    case (ctrl)
      4'b0000: alu_calc = a & b;
      4'b0001: alu_calc = a | b;
      4'b0010: alu_calc = a + b;
      4'b0110: alu_calc = a - b;
      4'b0111: alu_calc = (a < b) ? 32'd1 : 32'd0;
      default: alu_calc = 32'd0;
    endcase
  endfunction

  // Registered ALU models: result one cycle after inputs, zero only on SUB.
  always_ff @(posedge clk) begin
    rr_alu_result <= alu_calc(rr_alu_ctrl, rr_alu_a, rr_alu_b);
    if (rr_alu_ctrl == 4'b0110) rr_alu_zero <= (rr_alu_a == rr_alu_b);
    fp_alu_result <= alu_calc(fp_alu_ctrl, fp_alu_a, fp_alu_b);
    if (fp_alu_ctrl == 4'b0110) fp_alu_zero <= (fp_alu_a == fp_alu_b);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and wait (bounded) for its handshake edge; returns in
  // the cycle right after acceptance with the valid dropped.
  task automatic applyStimulus(input logic id, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               output logic ok);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((id == 1'b0 && rr_req0_ready) || (id == 1'b1 && rr_req1_ready)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Full transaction with latency and response checks, then response release.
  task automatic run_op(input string tag, input logic id, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_data, input logic exp_zero,
                        input logic exp_err);
    logic ok;
    applyStimulus(id, op, a, b, ok);
    if (!ok) return;
    if (!exp_err) begin
      checkOutput({tag, "_exec_valid"}, {31'd0, rr_resp_valid}, 32'd0);
      checkOutput({tag, "_exec_ctrl"}, {28'd0, rr_alu_ctrl}, {28'd0, op});
      tick();
      checkOutput({tag, "_capt_valid"}, {31'd0, rr_resp_valid}, 32'd0);
      tick();
    end else begin
      checkOutput({tag, "_err_ctrl"}, {28'd0, rr_alu_ctrl}, 32'd0);
    end
    checkOutput({tag, "_valid"}, {31'd0, rr_resp_valid}, 32'd1);
    checkOutput({tag, "_data"}, rr_resp_data, exp_data);
    checkOutput({tag, "_id"}, {31'd0, rr_resp_id}, {31'd0, id});
    checkOutput({tag, "_zero"}, {31'd0, rr_resp_zero}, {31'd0, exp_zero});
    checkOutput({tag, "_err"}, {31'd0, rr_resp_err}, {31'd0, exp_err});
    checkOutput({tag, "_fp_data"}, fp_resp_data, exp_data);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput({tag, "_done_valid"}, {31'd0, rr_resp_valid}, 32'd0);
    checkOutput({tag, "_done_busy"}, {31'd0, rr_busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic ok;
    int   n_rr;
    int   n_fp;
    logic ids_rr [4];
    logic ids_fp [4];

    // Reset values
    do_reset();
    checkOutput("rst_valid", {31'd0, rr_resp_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, rr_busy}, 32'd0);
    checkOutput("rst_ready", {30'd0, rr_req1_ready, rr_req0_ready}, 32'd0);
    checkOutput("rst_alu", rr_alu_a | rr_alu_b | {28'd0, rr_alu_ctrl}, 32'd0);
    checkOutput("rst_data", rr_resp_data, 32'd0);

    // Basic ops, stale-zero, wrap and unsigned SLT
    run_op("add", 1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    run_op("sub_eq", 1'b1, 4'b0110, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0);
    run_op("and_stale", 1'b1, 4'b0000, 32'd0, 32'hF, 32'd0, 1'b0, 1'b0);
    run_op("add_wrap", 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0);
    run_op("slt_uns", 1'b1, 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_op("sub_ne", 1'b0, 4'b0110, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0);

    // Illegal op: direct to RESP with err
    run_op("illegal", 1'b0, 4'b1111, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1);

    // Back-pressure with a competing request pending
    applyStimulus(1'b0, 4'b0010, 32'd10, 32'd20, ok);
    tick();
    tick();
    req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'd3; req1_b = 32'd4;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {31'd0, rr_resp_valid}, 32'd1);
      checkOutput("bp_data", rr_resp_data, 32'd30);
      checkOutput("bp_ready1", {31'd0, rr_req1_ready}, 32'd0);
      checkOutput("bp_busy", {31'd0, rr_busy}, 32'd1);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput("bp_rel_valid", {31'd0, rr_resp_valid}, 32'd0);
    checkOutput("bp_rel_busy", {31'd0, rr_busy}, 32'd0);
    checkOutput("bp_rel_ready1", {31'd0, rr_req1_ready}, 32'd1);
    req1_valid = 1'b0;
    #1;

    // Arbitration order with both requesters held valid
    do_reset();
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd2; req1_b = 32'd2;
    resp_ready = 1'b1;
    n_rr = 0;
    n_fp = 0;
    for (int i = 0; i < 60 && (n_rr < 4 || n_fp < 4); i++) begin
      tick();
      if (rr_resp_valid && n_rr < 4) begin
        ids_rr[n_rr] = rr_resp_id;
        n_rr++;
      end
      if (fp_resp_valid && n_fp < 4) begin
        ids_fp[n_fp] = fp_resp_id;
        n_fp++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checkOutput("rr_count", n_rr, 32'd4);
    checkOutput("fp_count", n_fp, 32'd4);
    for (int i = 0; i < 4 && i < n_rr; i++)
      checkOutput($sformatf("rr_order%0d", i), {31'd0, ids_rr[i]}, i % 2);
    for (int i = 0; i < 4 && i < n_fp; i++)
      checkOutput($sformatf("fp_order%0d", i), {31'd0, ids_fp[i]}, 32'd0);
    for (int i = 0; i < 10 && (rr_busy || fp_busy); i++) tick();
    resp_ready = 1'b0;
    checkOutput("arb_idle", {30'd0, rr_busy, fp_busy}, 32'd0);

    // Reset during CAPT discards the operation
    applyStimulus(1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstc_valid", {31'd0, rr_resp_valid}, 32'd0);
    checkOutput("rstc_busy", {31'd0, rr_busy}, 32'd0);
    checkOutput("rstc_alu", rr_alu_a | rr_alu_b | {28'd0, rr_alu_ctrl}, 32'd0);
    checkOutput("rstc_resp", rr_resp_data | {29'd0, rr_resp_id, rr_resp_zero, rr_resp_err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rstc_quiet", {31'd0, rr_resp_valid}, 32'd0);
    end
    run_op("or_after", 1'b0, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
